// File: rtl/vga_capture_pkg.sv
// vga_capture shared types, screen geometry and address helpers.
// pix_addr maps (x,y) to y*160+x; in_screen tests x<160 and y<120.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int FB_DEPTH = 19200;
  localparam int FB_AW    = 15;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } cap_state_t;

  function automatic logic [FB_AW-1:0] pix_addr(
    input logic [7:0] x,
    input logic [6:0] y
  );
    logic [FB_AW-1:0] yy;
    yy = FB_AW'(y);
    return (yy << 7) + (yy << 5) + FB_AW'(x);
  endfunction

  function automatic logic in_screen(
    input logic [7:0] x,
    input logic [6:0] y
  );
    return (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));
  endfunction

endpackage

// File: rtl/vga_capture_if.sv
// Pixel-plot bus: coordinates, colour, plot strobe and clear request.
// master drives the plot bus; slave (the capture block) drives ready.
interface vga_capture_if;

  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       clr;
  logic       ready;

  modport master (
    output vga_x, vga_y, vga_colour,
    output vga_plot, clr,
    input  ready
  );

  modport slave (
    input  vga_x, vga_y, vga_colour,
    input  vga_plot, clr,
    output ready
  );

endinterface

// File: rtl/vga_capture_fb_ram.sv
// 19200x3 frame buffer: one write port, one registered read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read, old data on collision).
module fb_ram
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [FB_AW-1:0] waddr,
  input  logic [2:0]       wdata,
  input  logic [FB_AW-1:0] raddr,
  output logic [2:0]       rdata
);

  logic [2:0] mem [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_capture.sv
// Captures in-range plots into a 160x120x3 buffer, counts plots, readback.
// Ports: clk, rst_n, bus (plot slave), rd_x/rd_y -> rd_colour/rd_valid, counters.
module vga_capture
  import vga_pkg::*;
#(
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_capture_if.slave  bus,
  input  logic [7:0]    rd_x,
  input  logic [6:0]    rd_y,
  output logic [2:0]    rd_colour,
  output logic          rd_valid,
  output logic [15:0]   plot_count,
  output logic [15:0]   oob_count
);

  localparam logic [FB_AW-1:0] LAST =
    FB_AW'(FB_DEPTH - 1);

  cap_state_t       state;
  logic [FB_AW-1:0] clr_addr;
  logic             ready_q;
  logic             rd_ok_q;
  logic [2:0]       ram_rdata;

  logic             clearing;
  logic             hit;
  logic             wr_ok;
  logic             wr_oob;
  logic             rd_ok;
  logic             we;
  logic [FB_AW-1:0] waddr;
  logic [2:0]       wdata;
  logic [FB_AW-1:0] raddr;

  assign clearing = (state == S_CLEAR);
  assign hit      = in_screen(bus.vga_x, bus.vga_y);
  assign wr_ok    = !clearing && bus.vga_plot && hit;
  assign wr_oob   = !clearing && bus.vga_plot && !hit;

  assign we    = clearing || wr_ok;
  assign waddr = clearing ? clr_addr
               : pix_addr(bus.vga_x, bus.vga_y);
  assign wdata = clearing ? CLEAR_COLOUR
               : bus.vga_colour;

  // Off-screen reads are parked at 0 and masked on the output.
  assign rd_ok = in_screen(rd_x, rd_y);
  assign raddr = rd_ok ? pix_addr(rd_x, rd_y) : '0;

  fb_ram u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  assign bus.ready = ready_q;
  assign rd_colour = rd_ok_q ? ram_rdata : 3'b000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_CLEAR;
      clr_addr   <= '0;
      ready_q    <= 1'b0;
      plot_count <= '0;
      oob_count  <= '0;
    end else begin
      unique case (state)
        S_CLEAR: begin
          // Counters held at zero for the whole clear, so a plot
          // taken on the clr edge is counted, then wiped here.
          plot_count <= '0;
          oob_count  <= '0;
          clr_addr   <= clr_addr + 1'b1;
          if (clr_addr == LAST) begin
            clr_addr <= '0;
            state    <= S_RUN;
            ready_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (wr_ok && plot_count != 16'hFFFF)
            plot_count <= plot_count + 1'b1;
          if (wr_oob && oob_count != 16'hFFFF)
            oob_count <= oob_count + 1'b1;
          if (bus.clr) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
            ready_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ok_q  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_ok_q  <= rd_ok;
      rd_valid <= ready_q;
    end
  end

endmodule

// File: doc/vga_capture.md
# vga_capture

Receiving end of the pixel-plot interface (`vga_x`, `vga_y`, `vga_colour`, `vga_plot`) driven by drawing blocks such as `circle`. It records every in-range plot into a 160x120x3 frame buffer, counts accepted and rejected plots, and exposes a registered readback port. Testbenches and on-chip checkers use it to inspect what a drawer produced without going through the analog VGA path. It sits in parallel with `vga_adapter` on the same plot bus.

## Interface

Parameters:
- `CLEAR_COLOUR`, 3'b000: value written to every pixel during a clear.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `vga_x`  in  8: plot column.
- `vga_y`  in  7: plot row.
- `vga_colour`  in  3: plot colour.
- `vga_plot`  in  1: plot strobe; one pixel per cycle while high.
- `clr`  in  1: request a full-buffer clear; sampled only in `S_RUN`.
- `ready`  out  1: high in `S_RUN`; plots are accepted only while high.
- `rd_x`  in  8: readback column.
- `rd_y`  in  7: readback row.
- `rd_colour`  out  3: pixel at (`rd_x`,`rd_y`), registered.
- `rd_valid`  out  1: `rd_colour` is meaningful.
- `plot_count`  out  16: accepted plots since last clear; saturates at 16'hFFFF.
- `oob_count`  out  16: rejected out-of-range plots since last clear; saturates.

## Operation

- Address: `addr = y*160 + x`, computed as `(y<<7) + (y<<5) + x` at 15 bits. Range 0..19199.
- In range: `x < 160` and `y < 120`. Out-of-range plots are never written and increment `oob_count`.
- FSM states:
  - `S_CLEAR`: writes `CLEAR_COLOUR` to address `clr_addr`, then increments it. `ready=0`. At `clr_addr==19199`, the write completes and the next state is `S_RUN`.
  - `S_RUN`: `ready=1`. If `vga_plot` is high and the plot is in range, write `vga_colour` to `addr` and increment `plot_count`. If `vga_plot` is high and the plot is out of range, increment `oob_count`. If `clr` is high, go to `S_CLEAR` next cycle with `clr_addr=0` and both counters zeroed. A plot in the same cycle as `clr` is still written and counted before the zeroing; zeroing takes priority on the next cycle.
- Plots while `ready=0` are dropped silently and are not counted.
- Readback: `rd_colour` is the memory contents at the readback address, registered. If `rd_x`/`rd_y` is out of range, `rd_colour` returns 3'b000.
- Read and write to the same address in the same cycle: readback returns the old value (read-before-write).
- Counters saturate at 16'hFFFF; they never wrap.

## Timing

- Reset (`rst_n` low at a rising edge), from any state including mid-clear or mid-run:
  - next state `S_CLEAR`, `clr_addr=0`;
  - `plot_count=0`, `oob_count=0`, `ready=0`, `rd_valid=0`, `rd_colour=0`.
- Clear duration: exactly 19200 cycles in `S_CLEAR`. `ready` rises on the cycle after the write to 19199.
- Write latency: a plot accepted at edge N is visible to a readback issued at edge N+1; data appears on `rd_colour` after edge N+2.
- Readback latency: 1 cycle. `rd_valid` equals `ready` delayed by one cycle.
- Counter latency: counters update at the same edge that accepts the plot.
- Back-to-back plots: sustained at 1 pixel per cycle with no stalls.

## Structure

- Package `vga_pkg`:
  - constants `SCREEN_W=160`, `SCREEN_H=120`, `FB_DEPTH=19200`, `FB_AW=15`;
  - `typedef enum logic {S_CLEAR, S_RUN} cap_state_t`;
  - function `pix_addr(x,y)`.
- Sub-module `fb_ram`: simple dual-port RAM, 19200x3, one write port and one registered read port, with read-before-write behaviour.
- Top level holds the FSM, clear address counter, range checks, saturating counters and readback gating.

## Test plan

- Reset, then wait 19200 cycles → `ready` rises on cycle 19201; a readback at (159,119) returns 3'b000 with `rd_valid=1`.
- Plot (10,20,colour 3'b101) once → `plot_count=1`; a readback at (10,20) returns 3'b101 two cycles after the plot edge.
- Plot (160,5) and then (3,120) → `oob_count=2`, `plot_count` unchanged, no memory change at (0,6) or (3,0).
- Plot 5 pixels while `ready=0` (during clear) → counters stay 0 and the pixels read back as `CLEAR_COLOUR` after the clear.
- Assert `clr` in the same cycle as plot (1,1,3'b111) → next cycle both counters are 0 and `ready=0`; after the clear, (1,1) reads 3'b000.
- Pull `rst_n` low at `clr_addr≈5000` during a clear → clear restarts from 0 and `ready` rises 19200 cycles after reset is released. Separately, issue 70000 plots in `S_RUN` → `plot_count` holds at 16'hFFFF.
